// File: rtl/jtag_tap_responder_if.sv
// Pin-level JTAG link plus the user register port of the TAP responder.
// The master modport is the side that drives TCK/TMS/TDI and provides USER_DR_IN.
interface jtag_tap_responder_if #(
  parameter int C_IR_LENGTH = 4,
  parameter int C_DR_LENGTH = 32
);
  logic                   TCK;
  logic                   TMS;
  logic                   TDI;
  logic                   TDO;
  logic [C_DR_LENGTH-1:0] USER_DR_IN;
  logic [C_DR_LENGTH-1:0] USER_DR_OUT;
  logic                   USER_UPDATE;
  logic [C_IR_LENGTH-1:0] IR_VALUE;
  logic [3:0]             TAP_STATE;

  modport master (
    output TCK, TMS, TDI, USER_DR_IN,
    input  TDO, USER_DR_OUT, USER_UPDATE, IR_VALUE, TAP_STATE
  );

  modport slave (
    input  TCK, TMS, TDI, USER_DR_IN,
    output TDO, USER_DR_OUT, USER_UPDATE, IR_VALUE, TAP_STATE
  );
endinterface

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP target oversampled in the CLK domain, with IDCODE, BYPASS and USER DRs.
//
// state | meaning
// TLR   | test-logic-reset, IR forced to IDCODE
// RTI   | run-test/idle
// SELDR | select DR scan
// CAPDR | capture selected DR
// SHDR  | shift selected DR, TDI -> MSB, LSB -> TDO
// EX1DR | exit1 DR
// PDR   | pause DR, shift reg holds
// EX2DR | exit2 DR
// UPDR  | update DR (USER_DR_OUT written on TCK fall)
// SELIR | select IR scan
// CAPIR | capture 2'b01 into IR shift reg
// SHIR  | shift IR
// EX1IR | exit1 IR
// PIR   | pause IR
// EX2IR | exit2 IR
// UPIR  | update IR (IR_VALUE written on TCK fall)
module jtag_tap_responder #(
  parameter int          C_IR_LENGTH    = 4,
  parameter int          C_DR_LENGTH    = 32,
  parameter logic [31:0] C_IDCODE       = 32'h1234_5679,
  parameter int          C_IDCODE_INSTR = 1,
  parameter int          C_USER_INSTR   = 2
) (
  input  logic                CLK,
  input  logic                RESETN,
  jtag_tap_responder_if.slave bus
);

  typedef enum logic [3:0] {
    TLR   = 4'h0, RTI   = 4'h1, SELDR = 4'h2, CAPDR = 4'h3,
    SHDR  = 4'h4, EX1DR = 4'h5, PDR   = 4'h6, EX2DR = 4'h7,
    UPDR  = 4'h8, SELIR = 4'h9, CAPIR = 4'hA, SHIR  = 4'hB,
    EX1IR = 4'hC, PIR   = 4'hD, EX2IR = 4'hE, UPIR  = 4'hF
  } tap_state_e;

  localparam logic [C_IR_LENGTH-1:0] IR_IDCODE  = C_IR_LENGTH'(C_IDCODE_INSTR);
  localparam logic [C_IR_LENGTH-1:0] IR_USER    = C_IR_LENGTH'(C_USER_INSTR);
  localparam logic [C_IR_LENGTH-1:0] IR_CAPTURE = C_IR_LENGTH'(2'b01);

  logic tck_s1, tck_s2, tck_d;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic tck_rise, tck_fall;

  tap_state_e state_q, state_d;

  logic in_tlr, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;

  logic [C_IR_LENGTH-1:0] ir_sr, ir_q;
  logic [31:0]            idcode_sr;
  logic [C_DR_LENGTH-1:0] user_sr, user_dr_out_q;
  logic                   bypass_q;
  logic                   user_update_q;
  logic                   tdo_q;
  logic                   sel_idcode, sel_user, dr_lsb;

  // Two-flop synchronisers, then one extra TCK stage so edges become 1-CLK strobes.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tck_s1 <= 1'b0;
      tck_s2 <= 1'b0;
      tck_d  <= 1'b0;
      tms_s1 <= 1'b0;
      tms_s2 <= 1'b0;
      tdi_s1 <= 1'b0;
      tdi_s2 <= 1'b0;
    end else begin
      tck_s1 <= bus.TCK;
      tck_s2 <= tck_s1;
      tck_d  <= tck_s2;
      tms_s1 <= bus.TMS;
      tms_s2 <= tms_s1;
      tdi_s1 <= bus.TDI;
      tdi_s2 <= tdi_s1;
    end
  end

  assign tck_rise = tck_s2 & ~tck_d;
  assign tck_fall = ~tck_s2 & tck_d;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= TLR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TLR:     state_d = tms_s2 ? TLR   : RTI;
        RTI:     state_d = tms_s2 ? SELDR : RTI;
        SELDR:   state_d = tms_s2 ? SELIR : CAPDR;
        CAPDR:   state_d = tms_s2 ? EX1DR : SHDR;
        SHDR:    state_d = tms_s2 ? EX1DR : SHDR;
        EX1DR:   state_d = tms_s2 ? UPDR  : PDR;
        PDR:     state_d = tms_s2 ? EX2DR : PDR;
        EX2DR:   state_d = tms_s2 ? UPDR  : SHDR;
        UPDR:    state_d = tms_s2 ? SELDR : RTI;
        SELIR:   state_d = tms_s2 ? TLR   : CAPIR;
        CAPIR:   state_d = tms_s2 ? EX1IR : SHIR;
        SHIR:    state_d = tms_s2 ? EX1IR : SHIR;
        EX1IR:   state_d = tms_s2 ? UPIR  : PIR;
        PIR:     state_d = tms_s2 ? EX2IR : PIR;
        EX2IR:   state_d = tms_s2 ? UPIR  : SHIR;
        UPIR:    state_d = tms_s2 ? SELDR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  always_comb begin
    in_tlr = 1'b0;
    cap_ir = 1'b0;
    sh_ir  = 1'b0;
    upd_ir = 1'b0;
    cap_dr = 1'b0;
    sh_dr  = 1'b0;
    upd_dr = 1'b0;
    case (state_q)
      TLR:     in_tlr = 1'b1;
      CAPIR:   cap_ir = 1'b1;
      SHIR:    sh_ir  = 1'b1;
      UPIR:    upd_ir = 1'b1;
      CAPDR:   cap_dr = 1'b1;
      SHDR:    sh_dr  = 1'b1;
      UPDR:    upd_dr = 1'b1;
      default: ;
    endcase
  end

  // Only IDCODE and USER codes decode; everything else falls through to BYPASS.
  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_user   = (ir_q == IR_USER) && !sel_idcode;
  assign dr_lsb     = sel_idcode ? idcode_sr[0] : (sel_user ? user_sr[0] : bypass_q);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ir_sr         <= '0;
      ir_q          <= IR_IDCODE;
      idcode_sr     <= '0;
      user_sr       <= '0;
      bypass_q      <= 1'b0;
      user_dr_out_q <= '0;
      user_update_q <= 1'b0;
      tdo_q         <= 1'b0;
    end else begin
      user_update_q <= 1'b0;
      if (tck_rise) begin
        if (in_tlr) ir_q  <= IR_IDCODE;
        if (cap_ir) ir_sr <= IR_CAPTURE;
        if (sh_ir)  ir_sr <= {tdi_s2, ir_sr[C_IR_LENGTH-1:1]};
        if (cap_dr) begin
          if (sel_idcode)    idcode_sr <= C_IDCODE;
          else if (sel_user) user_sr   <= bus.USER_DR_IN;
          else               bypass_q  <= 1'b0;
        end
        if (sh_dr) begin
          if (sel_idcode)    idcode_sr <= {tdi_s2, idcode_sr[31:1]};
          else if (sel_user) user_sr   <= {tdi_s2, user_sr[C_DR_LENGTH-1:1]};
          else               bypass_q  <= tdi_s2;
        end
      end
      // TDO changes on the falling edge so the master sees it stable at the next rise.
      if (tck_fall) begin
        if (upd_ir) ir_q <= ir_sr;
        if (upd_dr && sel_user) begin
          user_dr_out_q <= user_sr;
          user_update_q <= 1'b1;
        end
        if (sh_ir)      tdo_q <= ir_sr[0];
        else if (sh_dr) tdo_q <= dr_lsb;
        else            tdo_q <= 1'b0;
      end
    end
  end

  assign bus.TDO         = tdo_q;
  assign bus.USER_DR_OUT = user_dr_out_q;
  assign bus.USER_UPDATE = user_update_q;
  assign bus.IR_VALUE    = ir_q;
  assign bus.TAP_STATE   = state_q;

endmodule
